// File: rtl/collect_data.sv
// collect_data: assembles a serial, MSB-first bit stream into 2*WIDTH-bit
// words and hands each word downstream through a valid/ready holding register.
// Partial frames are discarded on sync_i, or after TIMEOUT cycles with no
// strobe. A word that completes while the holding register is still full and
// not being consumed is dropped, and the sticky overrun flag is set.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | no bits of a frame held
//   SHIFT | 1 to 2*WIDTH-1 bits of a frame held
module collect_data #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      bit_valid_i,
    input  logic                      bit_i,
    input  logic                      sync_i,
    input  logic                      data_ready_i,
    output logic signed [2*WIDTH-1:0] data_o,
    output logic                      data_valid_o,
    output logic                      busy_o,
    output logic                      overrun_o,
    output logic                      timeout_o
);

    localparam int WW     = 2 * WIDTH;
    localparam int CNT_W  = $clog2(WW) + 1;
    localparam int IDLE_W = $clog2(TIMEOUT) + 1;

    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WW - 1);
    localparam logic [IDLE_W-1:0] IDLE_TC  = IDLE_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [IDLE_W-1:0]        idle_q, idle_d;
    // At most WW-1 bits are ever held; the final bit goes straight into the word.
    logic [WW-2:0]            shift_q, shift_d;
    logic signed [WW-1:0]     data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     overrun_q, overrun_d;
    logic                     timeout_q, timeout_d;

    logic [WW-1:0]            word;
    logic                     complete;

    assign word = {shift_q, bit_i};

    // Registers: state, counters, shift register and output holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idle_q    <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idle_q    <= idle_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    // Frame collection: sync, bit acceptance, completion and idle timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idle_d    = idle_q;
        shift_d   = shift_q;
        timeout_d = 1'b0;
        complete  = 1'b0;

        if (sync_i) begin
            // Resync wins over completion; a strobed bit starts a new frame.
            idle_d = '0;
            if (bit_valid_i) begin
                shift_d = {{(WW-2){1'b0}}, bit_i};
                cnt_d   = CNT_W'(1);
                state_d = SHIFT;
            end else begin
                shift_d = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (bit_valid_i) begin
                        shift_d = {{(WW-2){1'b0}}, bit_i};
                        cnt_d   = CNT_W'(1);
                        idle_d  = '0;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_valid_i) begin
                        idle_d = '0;
                        if (cnt_q == LAST_BIT) begin
                            complete = 1'b1;
                            shift_d  = '0;
                            cnt_d    = '0;
                            state_d  = IDLE;
                        end else begin
                            shift_d = word[WW-2:0];
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
                    end else if (idle_q == IDLE_TC) begin
                        shift_d   = '0;
                        cnt_d     = '0;
                        idle_d    = '0;
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idle_d  = '0;
                    shift_d = '0;
                end
            endcase
        end
    end

    // Output holding register: load on completion if free or draining, else flag overrun.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (complete) begin
            if (!valid_q || data_ready_i) begin
                data_d  = $signed(word);
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && data_ready_i) begin
            valid_d = 1'b0;
        end
    end

    assign data_o       = data_q;
    assign data_valid_o = valid_q;
    assign busy_o       = (state_q == SHIFT);
    assign overrun_o    = overrun_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_collect_data.sv
// Bench for collect_data: directed scenarios plus randomized traffic, all
// checked each cycle against a frame-level model (bit count, accumulated
// value, quiet-cycle count), with literal expectations pinning the model.
module tb_collect_data;

    localparam int W  = 16;
    localparam int WW = 2 * W;
    localparam int TO = 40;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               bv = 1'b0;
    logic               b = 1'b0;
    logic               sync = 1'b0;
    logic               ready = 1'b0;
    logic signed [WW-1:0] data_o;
    logic               data_valid_o;
    logic               busy_o;
    logic               overrun_o;
    logic               timeout_o;

    always #5 clk = ~clk;

    collect_data #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .bit_valid_i  (bv),
        .bit_i        (b),
        .sync_i       (sync),
        .data_ready_i (ready),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .busy_o       (busy_o),
        .overrun_o    (overrun_o),
        .timeout_o    (timeout_o)
    );

    int checks   = 0;
    int failures = 0;
    bit checking = 1'b0;

    // Frame-level model
    int          m_nbits = 0;
    int          m_quiet = 0;
    logic [31:0] m_acc   = '0;
    logic [31:0] m_data  = '0;
    bit          m_valid = 1'b0;
    bit          m_ovr   = 1'b0;
    bit          m_to    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic v, input logic bi,
                                input logic s, input logic rd);
        bit done;
        done = 1'b0;
        if (r) begin
            m_nbits = 0; m_quiet = 0; m_acc = '0;
            m_data = '0; m_valid = 1'b0; m_ovr = 1'b0; m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            if (s) begin
                m_nbits = v ? 1 : 0;
                m_acc   = v ? {31'b0, bi} : 32'b0;
                m_quiet = 0;
            end else if (v) begin
                m_acc   = {m_acc[30:0], bi};
                m_nbits = m_nbits + 1;
                m_quiet = 0;
                if (m_nbits == WW) begin
                    done    = 1'b1;
                    m_nbits = 0;
                end
            end else if (m_nbits > 0) begin
                m_quiet = m_quiet + 1;
                if (m_quiet == TO) begin
                    m_nbits = 0;
                    m_quiet = 0;
                    m_to    = 1'b1;
                end
            end
            if (done) begin
                if (!m_valid || rd) begin
                    m_data  = m_acc;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && rd) begin
                m_valid = 1'b0;
            end
        end
    endtask

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            chk("data_o",       32'(data_o),       m_data);
            chk("data_valid_o", 32'(data_valid_o), 32'(m_valid));
            chk("busy_o",       32'(busy_o),       32'(m_nbits > 0));
            chk("overrun_o",    32'(overrun_o),    32'(m_ovr));
            chk("timeout_o",    32'(timeout_o),    32'(m_to));
        end
    end

    task automatic step(input logic r, input logic v, input logic bi,
                        input logic s, input logic rd);
        rst = r; bv = v; b = bi; sync = s; ready = rd;
        @(posedge clk);
        model_update(r, v, bi, s, rd);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input logic rd);
        for (int i = 31; i >= 0; i--) step(1'b0, 1'b1, w[i], 1'b0, rd);
    endtask

    bit dense;
    logic v_r;

    initial begin
        // Reset
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        checking = 1'b1;
        chk("reset_data",    32'(data_o),       32'h0);
        chk("reset_valid",   32'(data_valid_o), 32'h0);
        chk("reset_busy",    32'(busy_o),       32'h0);
        chk("reset_overrun", 32'(overrun_o),    32'h0);
        chk("reset_timeout", 32'(timeout_o),    32'h0);

        // Basic word, ready high
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("busy_bit1", 32'(busy_o), 32'h1);
        for (int i = 30; i >= 1; i--) step(1'b0, 1'b1, 1'(32'hDEADBEEF >> i), 1'b0, 1'b1);
        chk("busy_bit31", 32'(busy_o), 32'h1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("deadbeef_data",  32'(data_o),       32'hDEADBEEF);
        chk("deadbeef_valid", 32'(data_valid_o), 32'h1);
        chk("deadbeef_busy",  32'(busy_o),       32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("deadbeef_drain", 32'(data_valid_o), 32'h0);

        // Overrun with ready low
        send_word(32'h12345678, 1'b0);
        send_word(32'h0000FFFF, 1'b0);
        chk("ovr_data",    32'(data_o),       32'h12345678);
        chk("ovr_valid",   32'(data_valid_o), 32'h1);
        chk("ovr_flag",    32'(overrun_o),    32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_drain_valid", 32'(data_valid_o), 32'h0);
        chk("ovr_sticky",      32'(overrun_o),    32'h1);

        // Completion on the same edge a held word is consumed
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(32'hA5A50F0F, 1'b0);
        for (int i = 31; i >= 1; i--) step(1'b0, 1'b1, 1'(32'h3C3CC3C3 >> i), 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("swap_data",    32'(data_o),       32'h3C3CC3C3);
        chk("swap_valid",   32'(data_valid_o), 32'h1);
        chk("swap_overrun", 32'(overrun_o),    32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Timeout after 10 bits
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < TO - 1; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("to_before_pulse", 32'(timeout_o), 32'h0);
        chk("to_before_busy",  32'(busy_o),    32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("to_pulse", 32'(timeout_o), 32'h1);
        chk("to_busy",  32'(busy_o),    32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("to_pulse_end", 32'(timeout_o), 32'h0);
        send_word(32'h00000001, 1'b1);
        chk("to_next_data", 32'(data_o), 32'h00000001);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Sync with a strobed bit mid-frame
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 31; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("sync_data",    32'(data_o),    32'h80000000);
        chk("sync_overrun", 32'(overrun_o), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-frame
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_mid_data",  32'(data_o),       32'h0);
        chk("rst_mid_valid", 32'(data_valid_o), 32'h0);
        chk("rst_mid_busy",  32'(busy_o),       32'h0);
        send_word(32'hCAFEF00D, 1'b1);
        chk("rst_next_data", 32'(data_o), 32'hCAFEF00D);

        // Randomized traffic
        dense = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            if (c % 250 == 0) dense = ($urandom_range(0, 2) != 0);
            v_r = dense ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 29) == 0);
            step($urandom_range(0, 1499) == 0, v_r, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)));
        end

        checking = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/collect_data.md
COLLECT_DATA -- requirements
Module: collect_data

Interface
REQ-001 Parameter WIDTH, default 16, half-word width; assembled word is 2*WIDTH bits.
REQ-002 Parameter TIMEOUT, default 1024, clock cycles without a bit strobe before an open frame is aborted.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 bit_valid_i  input  1  strobe; bit_i is accepted on each clk edge where this is high.
REQ-006 bit_i  input  1  serial data bit, MSB of word first.
REQ-007 sync_i  input  1  frame resync; discards any partial frame.
REQ-008 data_ready_i  input  1  downstream accepts data_o when high together with data_valid_o.
REQ-009 data_o  output  2*WIDTH signed  last completed word.
REQ-010 data_valid_o  output  1  data_o holds an unconsumed word.
REQ-011 busy_o  output  1  high while a frame is partially collected.
REQ-012 overrun_o  output  1  sticky flag; a completed word was dropped.
REQ-013 timeout_o  output  1  one-cycle pulse; partial frame aborted by timeout.

Function
REQ-014 FSM states: IDLE (no bits held), SHIFT (1 to 2*WIDTH-1 bits held); busy_o = (state == SHIFT), registered.
REQ-015 Shift rule: each accepted bit enters shift register LSB side, older bits move toward MSB; first bit of frame ends at data_o[2*WIDTH-1].
REQ-016 IDLE + bit_valid_i: accept bit, bit count = 1, go SHIFT.
REQ-017 SHIFT + bit_valid_i: accept bit, count increments; on accepting bit number 2*WIDTH the frame completes, count = 0, go IDLE.
REQ-018 Completion latency: completed word {shift[2*WIDTH-2:0], bit_i} is visible on data_o with data_valid_o = 1 in the cycle after the edge that sampled the last bit.
REQ-019 data_valid_o stays high and data_o stays stable until an edge with data_valid_o = 1 and data_ready_i = 1; that edge clears data_valid_o.
REQ-020 Completion while data_valid_o = 1 and data_ready_i = 1 in the same cycle: new word loaded, data_valid_o stays 1, no overrun.
REQ-021 Completion while data_valid_o = 1 and data_ready_i = 0: new word dropped, data_o unchanged, overrun_o set to 1; overrun_o clears only on rst.
REQ-022 Timeout: idle counter in SHIFT counts cycles without bit_valid_i; reset to 0 on every accepted bit and on entry to IDLE.
REQ-023 When idle counter reaches TIMEOUT-1 with no bit_valid_i: partial frame discarded, count = 0, go IDLE, timeout_o = 1 for exactly the following cycle.
REQ-024 bit_valid_i in the cycle the timeout would fire: bit accepted, no timeout.
REQ-025 sync_i = 1 (any state): partial frame discarded, count = 0, idle counter = 0; if bit_valid_i = 1 in same cycle, that bit becomes bit 1 of a new frame (state SHIFT), else IDLE.
REQ-026 sync_i has no effect on data_o, data_valid_o or overrun_o.
REQ-027 sync_i on the cycle that would deliver bit 2*WIDTH: frame not completed; bit treated per REQ-025.
REQ-028 Bit counter width ceil(log2(2*WIDTH))+1; no wrap-around beyond 2*WIDTH is possible.

Reset
REQ-029 rst = 1 at an edge: state IDLE, count = 0, idle counter = 0, shift register = 0, data_o = 0, data_valid_o = 0, busy_o = 0, overrun_o = 0, timeout_o = 0.
REQ-030 rst has priority over all inputs; a frame in progress is discarded and inputs in the reset cycle are ignored.

Verification
REQ-031 32 strobed bits of 0xDEADBEEF, MSB first, data_ready_i = 1 -> data_o = 0xDEADBEEF, data_valid_o high one cycle after the last bit, for one cycle; busy_o high from bit 1 to bit 31.
REQ-032 Words 0x12345678 then 0x0000FFFF, data_ready_i = 0 throughout -> data_o = 0x12345678, data_valid_o = 1, overrun_o = 1 after second word; data_ready_i = 1 one cycle -> data_valid_o = 0, overrun_o stays 1.
REQ-033 10 bits then no strobes for TIMEOUT cycles -> timeout_o single pulse, busy_o = 0; following 32 bits of 0x00000001 -> data_o = 0x00000001.
REQ-034 16 bits of 0xFFFF, then sync_i with bit_valid_i (bit = 1), then 31 bits of 0x0 -> data_o = 0x80000000, no timeout, no overrun.
REQ-035 rst asserted after 20 bits of a frame -> all outputs 0; next 32 bits of 0xCAFEF00D -> data_o = 0xCAFEF00D.
REQ-036 Word completes on the same edge data_ready_i accepts a held word -> data_o = new word, data_valid_o stays 1, overrun_o = 0.
